multicycle_controller: RTL

- FSM control unit that sequences the shared-memory multicycle datapath for the team's 9-instruction MIPS subset: R-type, ADDI, SLTI, LW, SW, BEQ, J, JR, JAL.
- It sits beside the datapath. It receives the IR opcode, the ALU zero flag and a memory ready handshake.
- It drives every datapath enable and mux select.
- It counts retired instructions and flags illegal opcodes.
- The ALU function decode (alu_op → operation) stays in the existing ALU controller.

---
 rtl/multicycle_controller.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle MIPS-subset datapath.
// Drives every datapath enable/select, counts retired instructions and flags illegal opcodes.
module multicycle_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             i_or_d,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic [1:0]       mem_to_reg,
  output logic [1:0]       reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             instr_done,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_LW   = 4'd3,
    S_WB_LW    = 4'd4,
    S_MEM_SW   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_WB_R     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_WB_I     = 4'd9,
    S_BEQ      = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12,
    S_JAL      = 4'd13
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done_c;

  // The zero flag is gated by pc_write_cond inside the datapath, never here.
  logic unused_zero;
  assign unused_zero = zero;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  // NOTE: every output gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    done_c        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'b00;
    reg_dst       = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        unique case (opcode)
          6'b000000:            state_d = S_EXEC_R;
          6'b000001, 6'b000010: state_d = S_EXEC_I;
          6'b000011, 6'b000100: state_d = S_MEM_ADDR;
          6'b000101:            state_d = S_BEQ;
          6'b000110:            state_d = S_JUMP;
          6'b000111:            state_d = S_JR;
          6'b001000:            state_d = S_JAL;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == 6'b000011) ? S_MEM_LW : S_MEM_SW;
      end
      S_MEM_LW: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = S_WB_LW;
      end
      S_WB_LW: begin
        mem_to_reg = 2'b01;
        reg_write  = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_SW: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        done_c    = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_dst   = 2'b01;
        reg_write = 1'b1;
        done_c    = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (opcode == 6'b000010) ? 2'b11 : 2'b00;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        done_c    = 1'b1;
        state_d   = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        done_c        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = 2'b10;
        done_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JR: begin
        pc_write = 1'b1;
        pc_src   = 2'b11;
        done_c   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        reg_write  = 1'b1;
        done_c     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset holds the FSM in FETCH, but FETCH must not present a live memory read.
    if (!rst) begin
      done_c        = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_src        = 2'b00;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 2'b00;
      reg_dst       = 2'b00;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      illegal_op    = 1'b0;
    end

    retired_d = retired_q + CNT_W'(done_c);
  end

  assign instr_done = done_c;
  assign retired    = retired_q;
  assign state      = state_q;

endmodule
